// File: rtl/regfile_mp.sv
// Multi-read-port register file: x0 hardwired to zero, write-to-read bypass, optional REGFILE_SCOREBOARD_EN pending-write scoreboard.
// Reads are combinational, the write lands at the clock edge, and there is no backpressure.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NUM_RD = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   ra,
    output logic [NUM_RD*XLEN-1:0] rd,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [XLEN-1:0]        wd,
    input  logic                   iss_v,
    input  logic [AW-1:0]          iss_a,
    output logic [NUM_RD-1:0]      busy
);

    logic [XLEN-1:0] mem_q [NREG];
    logic            wr_en;

    assign wr_en = we && (wa != '0);

    // Entry 0 is cleared by reset and never written, so it always reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wa] <= wd;
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rst && (ra[i*AW +: AW] != '0)) begin
                if (we && (wa == ra[i*AW +: AW])) begin
                    rd[i*XLEN +: XLEN] = wd;
                end else begin
                    rd[i*XLEN +: XLEN] = mem_q[ra[i*AW +: AW]];
                end
            end
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // The issue set is applied after the write clear, so a same-cycle set wins.
    always_comb begin
        sb_d = sb_q;
        if (wr_en) begin
            sb_d[wa] = 1'b0;
        end
        if (iss_v && (iss_a != '0)) begin
            sb_d[iss_a] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rst) begin
                busy[i] = sb_q[ra[i*AW +: AW]] & ~(we && (wa == ra[i*AW +: AW]));
            end
        end
    end
`else
    logic unused_iss;

    assign unused_iss = ^{iss_v, iss_a};
    assign busy       = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default 2-port instance and a 4-port/64-bit/16-entry instance, checked against a scoreboard queue.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_v;
    logic [4:0]  iss_a;
    logic [1:0]  busy;

    logic [15:0]  m_ra;
    logic [255:0] m_rd;
    logic         m_we;
    logic [3:0]   m_wa;
    logic [63:0]  m_wd;
    logic         m_iss_v;
    logic [3:0]   m_iss_a;
    logic [3:0]   m_busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q [$];

    logic [31:0] ref_mem [32];
    logic [31:0] ref_sb;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
        .iss_v(iss_v), .iss_a(iss_a), .busy(busy)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NUM_RD(4)) u_mp (
        .clk(clk), .rst(rst), .ra(m_ra), .rd(m_rd), .we(m_we), .wa(m_wa), .wd(m_wd),
        .iss_v(m_iss_v), .iss_a(m_iss_a), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [63:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic w,
                                             input logic [4:0] wadr, input logic [31:0] wdat);
        if (a == 5'd0) return 32'd0;
        if (w && wadr == a) return wdat;
        return ref_mem[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a, input logic w, input logic [4:0] wadr);
`ifdef REGFILE_SCOREBOARD_EN
        return ref_sb[a] & ~(w && wadr == a);
`else
        return 1'b0 & a[0] & w & wadr[0];
`endif
    endfunction

    initial begin
        rst = 1'b0; ra = '0; we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_a = '0;
        m_ra = '0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_iss_v = 1'b0; m_iss_a = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        push(64'd0); chk("reset_rd", rd);
        push(64'd0); chk("reset_busy", {62'd0, busy});
        rst = 1'b1;

        // Async reset clears stored data immediately
        nxt();
        we = 1'b1; wa = 5'd5; wd = 32'd5;
        nxt();
        we = 1'b0; ra = {5'd5, 5'd5};
        #1;
        push(64'd5); chk("pre_reset_rd0", {32'd0, rd[31:0]});
        push(64'd5); chk("pre_reset_rd1", {32'd0, rd[63:32]});
        #2 rst = 1'b0;
        #1;
        push(64'd0); chk("async_reset_rd", rd);
        we = 1'b1; wa = 5'd5; wd = 32'd9;
        #1;
        push(64'd0); chk("reset_bypass_blocked", rd);
        nxt();
        we = 1'b0; rst = 1'b1;
        #1;
        push(64'd0); chk("post_reset_rd5", {32'd0, rd[31:0]});

        // Write then read, and writes to x0 are discarded
        we = 1'b1; wa = 5'd6; wd = 32'h4; ra = '0;
        nxt();
        we = 1'b0; ra = {5'd0, 5'd6};
        #1;
        push(64'd4); chk("write_read6", {32'd0, rd[31:0]});
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra = '0;
        #1;
        push(64'd0); chk("x0_bypass", rd);
        nxt();
        we = 1'b0;
        #1;
        push(64'd0); chk("x0_stored", rd);

        // Bypass hides the old stored value
        we = 1'b1; wa = 5'd7; wd = 32'h1111;
        nxt();
        we = 1'b0; ra = {5'd7, 5'd7};
        #1;
        push(64'h1111); chk("old7", {32'd0, rd[31:0]});
        we = 1'b1; wd = 32'hDEAD_BEEF;
        #1;
        push(64'hDEAD_BEEF); chk("bypass_rd0", {32'd0, rd[31:0]});
        push(64'hDEAD_BEEF); chk("bypass_rd1", {32'd0, rd[63:32]});
        ra = {5'd6, 5'd7};
        #1;
        push(64'h4); chk("bypass_other_port", {32'd0, rd[63:32]});
        nxt();
        we = 1'b0;
        #1;
        push(64'hDEAD_BEEF); chk("stored7", {32'd0, rd[31:0]});

        // Four-port instance
        for (int i = 1; i < 16; i++) begin
            m_we = 1'b1; m_wa = 4'(i); m_wd = 64'(i * 3);
            nxt();
        end
        m_we = 1'b0; m_ra = {4'd8, 4'd0, 4'd15, 4'd1};
        #1;
        push(64'd3);  chk("mp_port0", m_rd[63:0]);
        push(64'd45); chk("mp_port1", m_rd[127:64]);
        push(64'd0);  chk("mp_port2", m_rd[191:128]);
        push(64'd24); chk("mp_port3", m_rd[255:192]);
        push(64'd0);  chk("mp_busy", {60'd0, m_busy});

        // Scoreboard
        ra = {5'd0, 5'd9};
        iss_v = 1'b1; iss_a = 5'd9;
        #1;
        push(64'd0); chk("sb_issue_same_cycle", {63'd0, busy[0]});
        nxt();
        iss_v = 1'b0;
        #1;
`ifdef REGFILE_SCOREBOARD_EN
        push(64'd1); chk("sb_busy_after_issue", {63'd0, busy[0]});
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        #1;
        push(64'd0); chk("sb_write_hides", {63'd0, busy[0]});
        nxt();
        we = 1'b0;
        #1;
        push(64'd0); chk("sb_cleared", {63'd0, busy[0]});
        iss_v = 1'b1; iss_a = 5'd9; we = 1'b1; wa = 5'd9;
        nxt();
        iss_v = 1'b0; we = 1'b0;
        #1;
        push(64'd1); chk("sb_set_wins", {63'd0, busy[0]});
`else
        push(64'd0); chk("sb_off_busy", {62'd0, busy});
`endif

        // Random run against the reference model, from a fresh reset
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        we = 1'b0; iss_v = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        ref_sb = '0;
        for (int n = 0; n < 10000; n++) begin
            logic [4:0] a0, a1;
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            iss_v = 1'($urandom_range(0, 1));
            iss_a = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            ra = {a1, a0};
            #1;
            push({32'd0, model_rd(a0, we, wa, wd)}); chk("rand_rd0", {32'd0, rd[31:0]});
            push({32'd0, model_rd(a1, we, wa, wd)}); chk("rand_rd1", {32'd0, rd[63:32]});
            push({62'd0, model_busy(a1, we, wa), model_busy(a0, we, wa)});
            chk("rand_busy", {62'd0, busy});
            @(posedge clk);
            if (we && wa != 5'd0) begin
                ref_mem[wa] = wd;
                ref_sb[wa] = 1'b0;
            end
            if (iss_v && iss_a != 5'd0) ref_sb[iss_a] = 1'b1;
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
